pwm_capture: RTL

PWM receiver/decoder: samples an asynchronous PWM waveform, measures its high time and period in CLK cycles, and reports the 8-bit duty value that produced it. It pairs with the 8-bit, 256-cycle-period PWM generator. Typical uses are loop-back self-test of the generator and reading external PWM sources onto the RAT input port. It also flags stuck-high and stuck-low lines and non-nominal periods.

---
 rtl/pwm_capture.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// PWM receiver/decoder. Samples an asynchronous PWM line, measures the high
// time and the period in clk cycles between synchronized rising edges, and
// reports the 8-bit duty value that produced the waveform. It also detects a
// line stuck high or low (no rising edge for TIMEOUT_CYC cycles) and flags any
// measured period that differs from the nominal one.
//
// Parameters:
//   PERIOD_CYC  - nominal PWM period in clk cycles
//   CNT_W       - width of the cycle counters and of period
//                 (2**CNT_W must exceed TIMEOUT_CYC)
//   TIMEOUT_CYC - cycles without a rising edge before the line is stuck
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   pwm_in     in   asynchronous PWM input
//   duty       out  last measured high time saturated to 255
//                   (0 / 255 after a stuck-low / stuck-high timeout)
//   period     out  last measured period in cycles (0 after a timeout)
//   valid      out  one-cycle strobe, the other outputs update with it
//   stuck      out  last report was a timeout rather than a full period
//   period_err out  last full-period measurement was not PERIOD_CYC
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int PERIOD_CYC  = 256,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             period_err
);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for a first rising edge, nothing to report yet
        ST_HIGH,   // inside the high phase of a measured period
        ST_LOW,    // inside the low phase of a measured period
        ST_STUCK   // timeout reported, waiting for the line to move
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] PERIOD_NOM  = CNT_W'(PERIOD_CYC);

    // Synchronizer chain: sync_meta may go metastable, s is the clean sample,
    // s_d is s one cycle later for edge detection.
    logic sync_meta;
    logic s;
    logic s_d;

    state_t           state;
    logic [CNT_W-1:0] pcnt;   // cycles since the last rise (period counter)
    logic [CNT_W-1:0] hcnt;   // cycles the line stayed high after the last rise

    logic       rise;
    logic       fall;
    logic       timeout_hit;
    logic [7:0] hcnt_sat;

    assign rise        = s & ~s_d;
    assign fall        = ~s & s_d;
    assign timeout_hit = (pcnt == TIMEOUT_VAL);
    assign hcnt_sat    = (|hcnt[CNT_W-1:8]) ? 8'hff : hcnt[7:0];

    // NOTE: every register here is written with <= so all of them sample the
    // pre-edge values; with = the synchronizer stages would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            s          <= 1'b0;
            s_d        <= 1'b0;
            state      <= ST_IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            duty       <= '0;
            period     <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            period_err <= 1'b0;
        end else begin
            sync_meta <= pwm_in;
            s         <= sync_meta;
            s_d       <= s;
            valid     <= 1'b0;

            // Period counter restarts at 1 on every rise so that the value seen
            // in the cycle of the next rise equals the period; it also restarts
            // the timeout window when a stuck line finally falls.
            if (rise) begin
                pcnt <= CNT_ONE;
            end else if (state == ST_STUCK && fall) begin
                pcnt <= '0;
            end else if (pcnt != CNT_MAX) begin
                pcnt <= pcnt + CNT_ONE;
            end

            // High-time counter counts the rise cycle itself plus every later
            // cycle the line stays high; it freezes from the fall onward.
            if (rise) begin
                hcnt <= CNT_ONE;
            end else if (state == ST_HIGH && s) begin
                hcnt <= hcnt + CNT_ONE;
            end

            // A rise always wins over a timeout in the same cycle.
            if (rise) begin
                if (state == ST_LOW) begin
                    duty       <= hcnt_sat;
                    period     <= pcnt;
                    period_err <= (pcnt != PERIOD_NOM);
                    stuck      <= 1'b0;
                    valid      <= 1'b1;
                end
                state <= ST_HIGH;
            end else if (state != ST_STUCK && timeout_hit) begin
                duty       <= s ? 8'hff : 8'h00;
                period     <= '0;
                period_err <= 1'b0;
                stuck      <= 1'b1;
                valid      <= 1'b1;
                state      <= ST_STUCK;
            end else begin
                case (state)
                    ST_HIGH:  if (fall) state <= ST_LOW;
                    ST_STUCK: if (fall) state <= ST_IDLE;
                    default:  state <= state;
                endcase
            end
        end
    end

endmodule
